// File: rtl/record_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : record_packer_if
//  Description : Field-beat input stream and packed-record output bundle for
//                record_packer.
//                slave  - packer side: consumes beats, produces records
//                master - producer/consumer side (stimulus, upstream logic)
//  Signals     : in_valid/in_ready/in_data/in_last/in_mode  field beat stream
//                out_valid/out_ready/out_record/out_mode/out_count  record out
//                err_long  one-cycle overlong-record pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface record_packer_if #(
    parameter int FIELD_W    = 8,
    parameter int NUM_FIELDS = 4,
    parameter int MODE_W     = 3
);
    localparam int CNT_W = $clog2(NUM_FIELDS + 1);

    logic                          in_valid;
    logic                          in_ready;
    logic [FIELD_W-1:0]            in_data;
    logic                          in_last;
    logic [MODE_W-1:0]             in_mode;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_FIELDS*FIELD_W-1:0] out_record;
    logic [MODE_W-1:0]             out_mode;
    logic [CNT_W-1:0]              out_count;
    logic                          err_long;

    modport slave (
        input  in_valid, in_data, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_record, out_mode, out_count, err_long
    );

    modport master (
        output in_valid, in_data, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_record, out_mode, out_count, err_long
    );
endinterface
`default_nettype wire

// File: rtl/record_packer.sv
`default_nettype none
// ============================================================================
//  Module      : record_packer
//  Description : Collects up to NUM_FIELDS field beats into one packed record.
//                Field i lands at out_record[i*FIELD_W +: FIELD_W]; fields
//                not written by a short record read as zero. A record that
//                reaches NUM_FIELDS beats without in_last is closed early;
//                the remaining beats up to in_last are discarded and err_long
//                pulses once for the first discarded beat.
//  Ports       : clk, rst (synchronous, active-high)
//                bus (record_packer_if.slave) beat input / record output
//  Revision    : 1.0  initial release
// ============================================================================
module record_packer #(
    parameter int FIELD_W    = 8,
    parameter int NUM_FIELDS = 4,
    parameter int MODE_W     = 3
) (
    input  wire logic      clk,
    input  wire logic      rst,
    record_packer_if.slave bus
);

    localparam int CNT_W = $clog2(NUM_FIELDS + 1);
    localparam int REC_W = NUM_FIELDS * FIELD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        OUT   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    logic [REC_W-1:0]   r_buf;
    logic [CNT_W-1:0]   r_count;
    logic [MODE_W-1:0]  r_mode;
    // Set when the record was cut at the field limit without in_last; the
    // first beat accepted in DRAIN consumes it and raises err_long.
    logic               r_drain_pending;
    logic               r_out_valid;
    logic [REC_W-1:0]   r_out_record;
    logic [MODE_W-1:0]  r_out_mode;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_err_long;

    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_first;
    logic [CNT_W-1:0]   w_idx;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_close;
    logic [MODE_W-1:0]  w_mode_next;
    logic [REC_W-1:0]   w_buf_next;

    assign w_in_ready  = !rst && (r_state != OUT);
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_first     = (r_state == IDLE);
    assign w_idx       = w_first ? '0 : r_count;
    assign w_cnt_next  = w_idx + CNT_W'(1);
    assign w_close     = bus.in_last || (w_cnt_next == CNT_W'(NUM_FIELDS));
    assign w_mode_next = w_first ? bus.in_mode : r_mode;

    // Assembly buffer including the current beat; the first beat of a record
    // starts from zero so short records never carry stale fields. The closing
    // beat is folded in here so the output register loads in the same edge.
    always_comb begin
        w_buf_next = w_first ? '0 : r_buf;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (w_idx == CNT_W'(i)) begin
                w_buf_next[i*FIELD_W +: FIELD_W] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_buf           <= '0;
            r_count         <= '0;
            r_mode          <= '0;
            r_drain_pending <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_record    <= '0;
            r_out_mode      <= '0;
            r_out_count     <= '0;
            r_err_long      <= 1'b0;
        end else begin
            r_err_long <= 1'b0;
            case (r_state)
                IDLE, FILL: begin
                    if (w_in_fire) begin
                        r_buf   <= w_buf_next;
                        r_count <= w_cnt_next;
                        r_mode  <= w_mode_next;
                        if (w_close) begin
                            r_state         <= OUT;
                            r_out_valid     <= 1'b1;
                            r_out_record    <= w_buf_next;
                            r_out_mode      <= w_mode_next;
                            r_out_count     <= w_cnt_next;
                            r_drain_pending <= !bus.in_last;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= r_drain_pending ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (w_in_fire) begin
                        if (r_drain_pending) begin
                            r_err_long      <= 1'b1;
                            r_drain_pending <= 1'b0;
                        end
                        if (bus.in_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_record = r_out_record;
    assign bus.out_mode   = r_out_mode;
    assign bus.out_count  = r_out_count;
    assign bus.err_long   = r_err_long;

endmodule
`default_nettype wire

// File: tb/tb_record_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_record_packer
//  Description : Self-checking bench for record_packer (FIELD_W=8,
//                NUM_FIELDS=4, MODE_W=3): directed scenarios with hand-computed
//                expectations plus a randomised back-pressure run against a
//                small behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_record_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    record_packer_if #(.FIELD_W(8), .NUM_FIELDS(4), .MODE_W(3)) bus ();

    record_packer #(.FIELD_W(8), .NUM_FIELDS(4), .MODE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Random-run model state
    logic [31:0] q_rec[$];
    logic [2:0]  q_mode[$];
    logic [2:0]  q_cnt[$];
    bit          drv_done;
    int          exp_err;

    // Present one beat from a falling edge, hold it until accepted, then drop
    // in_valid just after the accepting edge. Returns at posedge+1.
    task automatic beat(input logic [7:0] d, input logic l, input logic [2:0] m);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_mode  = m;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL beat_timeout data=%h in_ready stayed 0, need 1", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long}
            !== {1'b0, 1'b0, 32'h0, 3'd0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state rdy=%b v=%b rec=%h mode=%h cnt=%h err=%b, need 0 everywhere",
                     bus.in_ready, bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b need=1", bus.in_ready);
        end
    endtask

    task automatic test_full_record();
        bus.out_ready = 1'b1;
        beat(8'h11, 1'b0, 3'd5);
        beat(8'h22, 1'b0, 3'd1);
        beat(8'h33, 1'b0, 3'd2);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_early_valid got=%b need=0", bus.out_valid);
        end
        beat(8'h44, 1'b1, 3'd3);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long, bus.in_ready}
            !== {1'b1, 32'h44332211, 3'd5, 3'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL full_record v=%b rec=%h mode=%0d cnt=%0d err=%b rdy=%b, need 1 44332211 5 4 0 0",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long, bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.out_valid, bus.in_ready, bus.err_long} !== 3'b010) begin
            bad++;
            $display("FAIL full_consumed v=%b rdy=%b err=%b, need 0 1 0",
                     bus.out_valid, bus.in_ready, bus.err_long);
        end
    endtask

    task automatic test_short_record();
        bus.out_ready = 1'b1;
        beat(8'hAA, 1'b0, 3'd6);
        beat(8'hBB, 1'b1, 3'd2);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count}
            !== {1'b1, 32'h0000BBAA, 3'd6, 3'd2}) begin
            bad++;
            $display("FAIL short_record v=%b rec=%h mode=%0d cnt=%0d, need 1 0000bbaa 6 2",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overlong();
        bus.out_ready = 1'b1;
        beat(8'h01, 1'b0, 3'd3);
        beat(8'h02, 1'b0, 3'd0);
        beat(8'h03, 1'b0, 3'd0);
        beat(8'h04, 1'b0, 3'd0);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long}
            !== {1'b1, 32'h04030201, 3'd3, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL overlong_record v=%b rec=%h mode=%0d cnt=%0d err=%b, need 1 04030201 3 4 0",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long);
        end
        beat(8'h05, 1'b0, 3'd0);
        total++;
        if ({bus.err_long, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL overlong_err_pulse err=%b v=%b, need 1 0", bus.err_long, bus.out_valid);
        end
        beat(8'h06, 1'b1, 3'd0);
        total++;
        if ({bus.err_long, bus.out_valid, bus.in_ready} !== 3'b001) begin
            bad++;
            $display("FAIL overlong_drain_end err=%b v=%b rdy=%b, need 0 0 1",
                     bus.err_long, bus.out_valid, bus.in_ready);
        end
        // Next record must start fresh at field 0 with a cleared buffer.
        beat(8'h77, 1'b1, 3'd1);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long}
            !== {1'b1, 32'h00000077, 3'd1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_drain_record v=%b rec=%h mode=%0d cnt=%0d err=%b, need 1 00000077 1 1 0",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        beat(8'h5A, 1'b0, 3'd2);
        beat(8'hC3, 1'b1, 3'd4);
        // Beats offered while the record waits must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_last  = 1'b1;
        bus.in_mode  = 3'd7;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.in_ready}
                !== {1'b1, 32'h0000C35A, 3'd2, 3'd2, 1'b0}) begin
                bad++;
                $display("FAIL backpressure_hold cyc=%0d v=%b rec=%h mode=%0d cnt=%0d rdy=%b, need 1 0000c35a 2 2 0",
                         i, bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_release v=%b rdy=%b, need 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_no_ghost v=%b, need 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_record();
        bus.out_ready = 1'b1;
        beat(8'h01, 1'b0, 3'd2);
        beat(8'h02, 1'b0, 3'd2);
        rst = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_low got=%b need=0", bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_count, bus.err_long} !== {1'b0, 32'h0, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_outputs v=%b rec=%h cnt=%0d err=%b, need 0 0 0 0",
                     bus.out_valid, bus.out_record, bus.out_count, bus.err_long);
        end
        beat(8'h0F, 1'b1, 3'd3);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count}
            !== {1'b1, 32'h0000000F, 3'd3, 3'd1}) begin
            bad++;
            $display("FAIL reset_next_record v=%b rec=%h mode=%0d cnt=%0d, need 1 0000000f 3 1",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count);
        end
        @(posedge clk); #1;

        // Reset while an overlong record is pending output: the drain flag
        // must not survive into the next record.
        bus.out_ready = 1'b0;
        beat(8'h31, 1'b0, 3'd1);
        beat(8'h32, 1'b0, 3'd1);
        beat(8'h33, 1'b0, 3'd1);
        beat(8'h34, 1'b0, 3'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_pending v=%b, need 0", bus.out_valid);
        end
        beat(8'h41, 1'b0, 3'd6);
        beat(8'h42, 1'b1, 3'd0);
        @(posedge clk); #1;
        beat(8'h51, 1'b1, 3'd4);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long}
            !== {1'b1, 32'h00000051, 3'd4, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL reset_drain_flag v=%b rec=%h mode=%0d cnt=%0d err=%b, need 1 00000051 4 1 0",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.err_long);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        beat(8'h10, 1'b1, 3'd1);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.in_ready}
            !== {1'b1, 32'h00000010, 3'd1, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_single v=%b rec=%h mode=%0d cnt=%0d rdy=%b, need 1 00000010 1 1 0",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count, bus.in_ready);
        end
        beat(8'h20, 1'b0, 3'd6);
        beat(8'h21, 1'b0, 3'd0);
        beat(8'h22, 1'b1, 3'd0);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count}
            !== {1'b1, 32'h00222120, 3'd6, 3'd3}) begin
            bad++;
            $display("FAIL b2b_three v=%b rec=%h mode=%0d cnt=%0d, need 1 00222120 6 3",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count);
        end
        beat(8'hFE, 1'b1, 3'd7);
        total++;
        if ({bus.out_valid, bus.out_record, bus.out_mode, bus.out_count}
            !== {1'b1, 32'h000000FE, 3'd7, 3'd1}) begin
            bad++;
            $display("FAIL b2b_cleared v=%b rec=%h mode=%0d cnt=%0d, need 1 000000fe 7 1",
                     bus.out_valid, bus.out_record, bus.out_mode, bus.out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int err_seen;
        int delivered;
        int guard;
        drv_done  = 1'b0;
        exp_err   = 0;
        err_seen  = 0;
        delivered = 0;
        guard     = 0;
        fork
            begin
                for (int r = 0; r < 1000; r++) begin
                    int          len;
                    logic [31:0] rec;
                    logic [2:0]  m;
                    logic [7:0]  d;
                    len = $urandom_range(1, 6);
                    rec = '0;
                    m   = 3'($urandom);
                    for (int b = 0; b < len; b++) begin
                        d = 8'($urandom);
                        if ($urandom_range(0, 3) == 0) begin
                            @(negedge clk);
                            bus.in_valid = 1'b0;
                            bus.in_data  = 8'($urandom);
                            bus.in_last  = 1'($urandom);
                        end
                        beat(d, (b == len - 1), (b == 0) ? m : 3'($urandom));
                        if (b < 4) rec[b*8 +: 8] = d;
                        if (b == len - 1 || b == 3) begin
                            if (b < 4) begin
                                q_rec.push_back(rec);
                                q_mode.push_back(m);
                                q_cnt.push_back(3'(b + 1));
                            end
                        end
                    end
                    if (len > 4) exp_err++;
                end
                drv_done = 1'b1;
            end
            begin
                while (guard < 60000) begin
                    @(negedge clk);
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    if (bus.err_long === 1'b1) err_seen++;
                    if (bus.out_valid && bus.out_ready) begin
                        total++;
                        if (q_rec.size() == 0) begin
                            bad++;
                            $display("FAIL rand_unexpected rec=%h, need no record", bus.out_record);
                        end else begin
                            logic [31:0] er;
                            logic [2:0]  em;
                            logic [2:0]  ec;
                            er = q_rec.pop_front();
                            em = q_mode.pop_front();
                            ec = q_cnt.pop_front();
                            delivered++;
                            if ({bus.out_record, bus.out_mode, bus.out_count} !== {er, em, ec}) begin
                                bad++;
                                $display("FAIL rand_record n=%0d got=%h/%0d/%0d need=%h/%0d/%0d",
                                         delivered, bus.out_record, bus.out_mode, bus.out_count, er, em, ec);
                            end
                        end
                    end
                    if (drv_done && q_rec.size() == 0) break;
                    guard++;
                end
            end
        join
        bus.out_ready = 1'b1;
        total++;
        if (guard >= 60000 || delivered != 1000) begin
            bad++;
            $display("FAIL rand_delivered got=%0d need=1000 (guard=%0d)", delivered, guard);
        end
        total++;
        if (err_seen != exp_err) begin
            bad++;
            $display("FAIL rand_err_count got=%0d need=%0d", err_seen, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_record();
        test_short_record();
        test_overlong();
        test_backpressure();
        test_reset_mid_record();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
